// File: rtl/modbus_uart_tx.sv
// Modbus RTU transmit back end: drains the 9-bit response FIFO and serialises each byte onto
// the RS-485 line, driving the transceiver enable and enforcing the post-frame silent gap.
// Word format: bit 8 set marks an end-of-frame token; bits [7:0] are then ignored.
// Build option: define MODBUS_TX_PARITY_EN for 8E1 framing; otherwise 8N2 is sent.
module modbus_uart_tx #(
  parameter int unsigned CLOCKS_PER_BIT = 868,
  parameter int unsigned GAP_BITS       = 39,
  parameter int unsigned DE_GUARD       = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       fifoEmpty,
  output logic       fifoReadReq,
  input  logic [8:0] fifoDataIn,
  output logic       txd,
  output logic       txEn,
  output logic       busy,
  output logic       frameDone
);

  localparam int unsigned DivW = $clog2(CLOCKS_PER_BIT);
  localparam logic [DivW-1:0] DivLast = DivW'(CLOCKS_PER_BIT - 1);
  localparam logic [15:0] GapLast   = 16'(GAP_BITS - 1);
  localparam logic [15:0] GuardLast = 16'(DE_GUARD - 1);
`ifdef MODBUS_TX_PARITY_EN
  localparam logic [15:0] StopLast  = 16'd0;
`else
  localparam logic [15:0] StopLast  = 16'd1;
`endif

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StFetch  = 3'd1;
  localparam logic [2:0] StStart  = 3'd2;
  localparam logic [2:0] StData   = 3'd3;
`ifdef MODBUS_TX_PARITY_EN
  localparam logic [2:0] StParity = 3'd4;
`endif
  localparam logic [2:0] StStop   = 3'd5;
  localparam logic [2:0] StGuard  = 3'd6;
  localparam logic [2:0] StGap    = 3'd7;

  logic [2:0]      state_q, state_d;
  logic [DivW-1:0] div_q, div_d;
  logic [15:0]     cnt_q, cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic            en_q, en_d;
`ifdef MODBUS_TX_PARITY_EN
  logic            par_q, par_d;
`endif
  logic            tick;
  logic            restart;

  assign tick = (div_q == DivLast);

  // Next-state logic for the framing FSM, bit counter, shifter and driver enable.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    en_d        = en_q;
`ifdef MODBUS_TX_PARITY_EN
    par_d       = par_q;
`endif
    fifoReadReq = 1'b0;
    frameDone   = 1'b0;
    case (state_q)
      StIdle: begin
        if (!fifoEmpty) begin
          fifoReadReq = 1'b1;
          state_d     = StFetch;
        end
      end
      StFetch: begin
        cnt_d = '0;
        if (fifoDataIn[8]) begin
          // With no guard time the enable drops straight into the gap.
          if (DE_GUARD == 0) begin
            en_d    = 1'b0;
            state_d = StGap;
          end else begin
            state_d = StGuard;
          end
        end else begin
          shift_d = fifoDataIn[7:0];
`ifdef MODBUS_TX_PARITY_EN
          par_d   = ^fifoDataIn[7:0];
`endif
          en_d    = 1'b1;
          state_d = StStart;
        end
      end
      StStart: begin
        if (tick) begin
          cnt_d   = '0;
          state_d = StData;
        end
      end
      StData: begin
        if (tick) begin
          shift_d = {1'b0, shift_q[7:1]};
          if (cnt_q == 16'd7) begin
            cnt_d   = '0;
`ifdef MODBUS_TX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end
`ifdef MODBUS_TX_PARITY_EN
      StParity: begin
        if (tick) begin
          cnt_d   = '0;
          state_d = StStop;
        end
      end
`endif
      StStop: begin
        if (tick) begin
          if (cnt_q == StopLast) begin
            cnt_d   = '0;
            state_d = StIdle;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end
      StGuard: begin
        if (tick) begin
          if (cnt_q == GuardLast) begin
            cnt_d   = '0;
            en_d    = 1'b0;
            state_d = StGap;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end
      StGap: begin
        if (tick) begin
          if (cnt_q == GapLast) begin
            cnt_d     = '0;
            frameDone = 1'b1;
            state_d   = StIdle;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end
      default: state_d = StGap;
    endcase
  end

  // Bit-time divider; realigned on entry to any timed state so each interval is a full bit.
  always_comb begin
    restart = (state_d != state_q) &&
              ((state_d == StStart) || (state_d == StGuard) || (state_d == StGap));
    div_d   = (restart || tick) ? '0 : div_q + DivW'(1);
  end

  // Line drivers decoded from state so reset forces the idle level immediately.
  always_comb begin
    case (state_q)
      StStart:  txd = 1'b0;
      StData:   txd = shift_q[0];
`ifdef MODBUS_TX_PARITY_EN
      StParity: txd = par_q;
`endif
      default:  txd = 1'b1;
    endcase
    txEn = en_q;
    busy = (state_q != StIdle);
  end

  // State registers; reset lands in the gap so the line is silent before the first frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StGap;
      div_q   <= '0;
      cnt_q   <= '0;
      shift_q <= '0;
      en_q    <= 1'b0;
`ifdef MODBUS_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      en_q    <= en_d;
`ifdef MODBUS_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

endmodule

// File: tb/tb_modbus_uart_tx.sv
// Directed bench for modbus_uart_tx with CLOCKS_PER_BIT=4, GAP_BITS=39, DE_GUARD=1.
// A character is 11 bit-times (44 clocks); the gap is 156 clocks; guard is 4 clocks.
module tb_modbus_uart_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       fifoEmpty;
  logic       fifoReadReq;
  logic [8:0] fifoDataIn = '0;
  logic       txd;
  logic       txEn;
  logic       busy;
  logic       frameDone;

  logic [8:0] mem [64];
  logic [5:0] wr_ptr = '0;
  logic [5:0] rd_ptr = '0;
  int         n_push = 0;
  int         req_cnt = 0;
  int         req_viol = 0;
  int         n_vec = 0;
  int         n_bad = 0;

  modbus_uart_tx #(
    .CLOCKS_PER_BIT(4),
    .GAP_BITS      (39),
    .DE_GUARD      (1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .fifoEmpty  (fifoEmpty),
    .fifoReadReq(fifoReadReq),
    .fifoDataIn (fifoDataIn),
    .txd        (txd),
    .txEn       (txEn),
    .busy       (busy),
    .frameDone  (frameDone)
  );

  always #5 clk = ~clk;

  assign fifoEmpty = (wr_ptr == rd_ptr);

  // FIFO model: word appears on fifoDataIn the cycle after the read strobe.
  always @(posedge clk) begin
    if (fifoReadReq) begin
      req_cnt <= req_cnt + 1;
      if (wr_ptr == rd_ptr) begin
        req_viol <= req_viol + 1;
      end else begin
        fifoDataIn <= mem[rd_ptr];
        rd_ptr     <= rd_ptr + 6'd1;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [8:0] w);
    mem[wr_ptr] = w;
    wr_ptr      = wr_ptr + 6'd1;
    n_push++;
  endtask

  // Called on an IDLE negedge just after pushing: start bit expected two clocks later.
  task automatic wait_start();
    int n;
    n = 0;
    while (txd !== 1'b0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("start_latency", 32'(n), 32'd2);
  endtask

  // Entered on the first START cycle; samples each bit mid-way, ends at clock 42 of 44.
  task automatic check_char(input logic [7:0] b);
    repeat (2) @(negedge clk);
    check("start_bit", 32'(txd), 32'd0);
    check("txen_start", 32'(txEn), 32'd1);
    for (int i = 0; i < 8; i++) begin
      repeat (4) @(negedge clk);
      check("data_bit", 32'(txd), 32'(b[i]));
    end
`ifdef MODBUS_TX_PARITY_EN
    repeat (4) @(negedge clk);
    check("parity_bit", 32'(txd), 32'(^b));
    repeat (4) @(negedge clk);
    check("stop_bit", 32'(txd), 32'd1);
`else
    repeat (4) @(negedge clk);
    check("stop_bit1", 32'(txd), 32'd1);
    repeat (4) @(negedge clk);
    check("stop_bit2", 32'(txd), 32'd1);
`endif
  endtask

  // From clock 42 of the last char: 1 stop clock, IDLE, FETCH, 4 guard clocks -> txEn low.
  task automatic finish_frame();
    int n;
    int bad;
    n   = 0;
    bad = 0;
    while (txEn === 1'b1 && n < 30) begin
      @(negedge clk);
      n++;
      if (txd !== 1'b1) bad++;
    end
    check("guard_len", 32'(n), 32'd8);
    check("guard_txd", 32'(bad), 32'd0);
    n   = 1;
    bad = 0;
    while (frameDone !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
      if (txEn !== 1'b0 || txd !== 1'b1) bad++;
    end
    check("gap_len", 32'(n), 32'd156);
    check("gap_quiet", 32'(bad), 32'd0);
    @(negedge clk);
    check("frame_done_pulse", 32'(frameDone), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
  endtask

  // From clock 42 of a char to the next start bit: stop clock, IDLE, FETCH, then START.
  task automatic back_to_back();
    int n;
    int bad;
    n   = 0;
    bad = 0;
    while (txd !== 1'b0 && n < 20) begin
      @(negedge clk);
      n++;
      if (txEn !== 1'b1) bad++;
    end
    check("b2b_gap", 32'(n), 32'd4);
    check("b2b_txen", 32'(bad), 32'd0);
  endtask

  initial begin
    int n;
    int bad;
    int t1;
    int t2;
    int np;

    // Reset state
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_txd", 32'(txd), 32'd1);
    check("rst_txen", 32'(txEn), 32'd0);
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_req", 32'(fifoReadReq), 32'd0);
    check("rst_done", 32'(frameDone), 32'd0);

    // Initial gap: 39 bit-times of 4 clocks, frameDone in the last one
    rst = 1'b1;
    n   = 1;
    bad = 0;
    while (frameDone !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
      if (txEn !== 1'b0 || txd !== 1'b1 || busy !== 1'b1) bad++;
    end
    check("init_gap_len", 32'(n), 32'd156);
    check("init_gap_quiet", 32'(bad), 32'd0);
    @(negedge clk);
    check("init_done_pulse", 32'(frameDone), 32'd0);
    check("init_idle", 32'(busy), 32'd0);

    // Single-byte frame 0x37
    push(9'h037);
    push(9'h100);
    wait_start();
    check_char(8'h37);
    finish_frame();

    // Back-to-back bytes keep the driver enabled
    push(9'h0A5);
    push(9'h033);
    push(9'h100);
    wait_start();
    check_char(8'hA5);
    back_to_back();
    check_char(8'h33);
    finish_frame();

    // Parity extremes 0xFF (even -> 0) and 0x01 (odd -> 1)
    push(9'h0FF);
    push(9'h001);
    push(9'h100);
    wait_start();
    check_char(8'hFF);
    back_to_back();
    check_char(8'h01);
    finish_frame();

    // Two empty frames: IDLE+FETCH+GUARD(4)+GAP(156) = 162 clocks between pulses
    push(9'h100);
    push(9'h100);
    bad = 0;
    t1  = -1;
    t2  = -1;
    np  = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (txEn !== 1'b0 || txd !== 1'b1) bad++;
      if (frameDone === 1'b1) begin
        np++;
        if (t1 < 0) t1 = c;
        else if (t2 < 0) t2 = c;
      end
    end
    check("empty_quiet", 32'(bad), 32'd0);
    check("empty_pulses", 32'(np), 32'd2);
    check("empty_spacing", 32'(t2 - t1), 32'd162);
    check("empty_idle", 32'(busy), 32'd0);

    // Reset during data bit 3 of 0xF0 (bit value 0)
    push(9'h0F0);
    push(9'h055);
    push(9'h100);
    wait_start();
    repeat (17) @(negedge clk);
    check("pre_rst_txd", 32'(txd), 32'd0);
    rst = 1'b0;
    #1;
    check("mid_rst_txd", 32'(txd), 32'd1);
    check("mid_rst_txen", 32'(txEn), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    // Full 156-clock gap, then IDLE and FETCH, start on clock 159
    n   = 1;
    bad = 0;
    while (txd !== 1'b0 && n < 300) begin
      @(negedge clk);
      n++;
      if (txd !== 1'b0 && txEn !== 1'b0) bad++;
    end
    check("post_rst_start", 32'(n), 32'd159);
    check("post_rst_quiet", 32'(bad), 32'd0);
    check_char(8'h55);
    finish_frame();

    // Every pushed word popped exactly once, never from an empty FIFO
    check("req_count", 32'(req_cnt), 32'(n_push));
    check("req_when_empty", 32'(req_viol), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
